step_controller: RTL and testbench
==================================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required before a button level is accepted.
REQ-002 Parameter CNT_W, default 16: width of the burst length and remaining-count fields.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 i_btn_run  in  1  raw run/halt toggle button, asynchronous to i_clk.
REQ-006 i_btn_step  in  1  raw single-step button, asynchronous.
REQ-007 i_btn_burst  in  1  raw burst-start button, asynchronous.
REQ-008 i_burst_len  in  CNT_W  number of enabled cycles per burst, sampled on burst acceptance.
REQ-009 i_halt_req  in  1  level halt request from the pipeline (e.g. breakpoint).
REQ-010 o_clk_en  out  1  pipeline clock enable, drives the datapath clock-enable input.
REQ-011 o_state  out  2  current state: HALT=00, RUN=01, STEP=10, BURST=11.
REQ-012 o_burst_rem  out  CNT_W  enabled cycles remaining in the current burst.
REQ-013 o_cycle_cnt  out  32  count of cycles with o_clk_en=1.

Function
REQ-014 Each button SHALL pass a 2-FF synchronizer, then a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from it.
REQ-015 A press SHALL be a one-cycle pulse on the debounced rising edge; releases generate nothing; a held button yields exactly one press.
REQ-016 o_clk_en SHALL be 1 exactly when o_state is RUN, STEP or BURST, decoded from the state register (no combinational path from inputs).
REQ-017 Press pulse in cycle t SHALL change the state at the edge ending cycle t; o_clk_en reflects it from cycle t+1.
REQ-018 HALT: run press -> RUN; step press -> STEP; burst press with i_burst_len!=0 -> BURST, o_burst_rem<=i_burst_len; burst press with i_burst_len=0 -> stay HALT.
REQ-019 HALT with i_halt_req=1: run and burst presses ignored; step press still -> STEP.
REQ-020 STEP: exactly one cycle, then HALT unconditionally; presses during STEP ignored.
REQ-021 RUN: stays RUN; run press or i_halt_req=1 -> HALT; step/burst presses ignored.
REQ-022 BURST: o_burst_rem decrements by 1 each cycle; in the cycle o_burst_rem=1 -> HALT with o_burst_rem<=0; run press or i_halt_req=1 aborts -> HALT, o_burst_rem<=0.
REQ-023 Simultaneous presses in HALT SHALL resolve by priority run > step > burst.
REQ-024 o_cycle_cnt SHALL increment by 1 each cycle o_clk_en=1 and wrap 0xFFFFFFFF -> 0.

Reset
REQ-025 i_rst=0 SHALL asynchronously force state HALT, o_clk_en=0, o_burst_rem=0, o_cycle_cnt=0, synchronizers, debounced levels and debounce counters to 0.
REQ-026 Reset asserted mid-RUN or mid-BURST SHALL drop o_clk_en in the same cycle; after release, the block waits in HALT; a button held through reset yields one press once debounced.

Configuration
REQ-027 Macro STEP_CONTROLLER_BURST_EN defined: burst logic present as specified.
REQ-028 Macro undefined: i_btn_burst and i_burst_len ignored, BURST unreachable, o_burst_rem tied to 0; all other behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, CNT_W=8, macro defined unless noted)
REQ-029 Reset, hold i_btn_step high 20 cycles -> exactly 1 cycle o_clk_en=1, o_cycle_cnt=1, o_state back to 00.
REQ-030 i_btn_step toggling every 2 cycles for 30 cycles (bounce) -> no press, o_clk_en stays 0.
REQ-031 i_burst_len=5, burst press -> o_clk_en high exactly 5 cycles, o_burst_rem 5,4,3,2,1 then 0, o_cycle_cnt=5.
REQ-032 Run press, then i_halt_req=1 after 10 enabled cycles -> HALT next edge, o_cycle_cnt=10; run press while i_halt_req=1 ignored; step press gives 1 cycle.
REQ-033 Run and step pressed same cycle -> RUN; burst press with i_burst_len=0 -> stays HALT; macro undefined, burst press with len 5 -> stays HALT.
REQ-034 Reset asserted mid-burst (o_burst_rem=3) -> o_clk_en=0 immediately, all outputs 0 after release.

Source files
------------

// File: rtl/step_controller.sv
// step_controller: run/halt/single-step/burst clock-enable controller for a
// debug pipeline. Three raw buttons are synchronized and debounced into
// one-cycle press pulses that drive a four-state FSM. The pipeline clock
// enable is decoded only from the state register.
//
// Optional feature macro: STEP_CONTROLLER_BURST_EN
//   defined   -> burst button starts a counted burst of enabled cycles
//   undefined -> burst button and burst length are ignored, BURST is
//                unreachable and o_burst_rem stays 0
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_run,
  input  logic             i_btn_step,
  input  logic             i_btn_burst,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic             i_halt_req,
  output logic             o_clk_en,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_burst_rem,
  output logic [31:0]      o_cycle_cnt
);

  // Debounce counter holds 0 .. DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_BURST = 2;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      press;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] burst_rem_q, burst_rem_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic            clk_en;

  assign btn_raw = {i_btn_burst, i_btn_step, i_btn_run};

  // Two-stage synchronizer feeding the debounce counters.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive synchronized samples that differ from the
  // accepted level; flip the level on the DEBOUNCE_CYCLES-th one. A press is
  // the cycle in which the accepted level flips from 0 to 1.
  always_comb begin
    db_d  = db_q;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]  = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Button front-end registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Clock enable comes straight from the state register.
  assign clk_en = (state_q != ST_HALT);

  // Next-state, burst countdown and enabled-cycle counter.
  always_comb begin
    state_d     = state_q;
`ifdef STEP_CONTROLLER_BURST_EN
    burst_rem_d = burst_rem_q;
`else
    burst_rem_d = '0;
`endif
    cycle_cnt_d = cycle_cnt_q + {31'd0, clk_en};

    case (state_q)
      ST_HALT: begin
        // Priority run > step > burst; a pending halt request blocks run
        // and burst but still allows a single step.
        if (press[BTN_RUN] && !i_halt_req) begin
          state_d = ST_RUN;
        end else if (press[BTN_STEP]) begin
          state_d = ST_STEP;
        end
`ifdef STEP_CONTROLLER_BURST_EN
        else if (press[BTN_BURST] && !i_halt_req && (i_burst_len != '0)) begin
          state_d     = ST_BURST;
          burst_rem_d = i_burst_len;
        end
`endif
      end
      ST_RUN: begin
        if (press[BTN_RUN] || i_halt_req) state_d = ST_HALT;
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
`ifdef STEP_CONTROLLER_BURST_EN
      ST_BURST: begin
        if (press[BTN_RUN] || i_halt_req || (burst_rem_q == CNT_W'(1))) begin
          state_d     = ST_HALT;
          burst_rem_d = '0;
        end else begin
          burst_rem_d = burst_rem_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_HALT;
      burst_rem_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_rem_q <= burst_rem_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

`ifndef STEP_CONTROLLER_BURST_EN
  // Burst inputs have no function in this build.
  logic unused_burst;
  assign unused_burst = ^{press[BTN_BURST], i_burst_len};
`endif

  assign o_clk_en    = clk_en;
  assign o_state     = state_q;
  assign o_burst_rem = burst_rem_q;
  assign o_cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed bench for step_controller with
// DEBOUNCE_CYCLES=4 and CNT_W=8. Burst scenarios follow the
// STEP_CONTROLLER_BURST_EN build option.
module tb_step_controller;

  localparam int DBC = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          rst_n;
  logic          btn_run, btn_step, btn_burst;
  logic [CW-1:0] burst_len;
  logic          halt_req;
  logic          clk_en;
  logic [1:0]    state;
  logic [CW-1:0] burst_rem;
  logic [31:0]   cycle_cnt;

  int n_cmp;
  int n_err;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] obs_q[$];

  step_controller #(
    .DEBOUNCE_CYCLES(DBC),
    .CNT_W          (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_btn_run  (btn_run),
    .i_btn_step (btn_step),
    .i_btn_burst(btn_burst),
    .i_burst_len(burst_len),
    .i_halt_req (halt_req),
    .o_clk_en   (clk_en),
    .o_state    (state),
    .o_burst_rem(burst_rem),
    .o_cycle_cnt(cycle_cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all input changes and output samples happen at negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_burst = 1'b0;
    halt_req  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Run n cycles, returning enabled-cycle count and the 1-based index of the
  // first enabled cycle (0 if none); burst_rem is logged while enabled.
  task automatic run_cycles(input int n, output int en_cnt, output int first_en);
    en_cnt   = 0;
    first_en = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (clk_en) begin
        en_cnt++;
        obs_q.push_back(burst_rem);
        if (first_en == 0) first_en = i;
      end
    end
  endtask

  initial begin
    int en, first;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_burst = 1'b0;
    burst_len = '0;
    halt_req  = 1'b0;

    // Reset state, sampled while reset is asserted.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_burst_rem", 32'(burst_rem), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    do_reset();

    // Held step button: one press, one enabled cycle, 6 edges of latency.
    btn_step = 1'b1;
    run_cycles(20, en, first);
    check("step_hold_en_cycles", 32'(en), 32'd1);
    check("step_hold_latency", 32'(first), 32'd6);
    check("step_hold_cycle_cnt", cycle_cnt, 32'd1);
    check("step_hold_state", 32'(state), 32'd0);
    btn_step = 1'b0;
    run_cycles(10, en, first);
    check("step_release_en", 32'(en), 32'd0);

    // Bouncing step button: runs of 2 equal samples never reach 4.
    for (int i = 0; i < 15; i++) begin
      btn_step = ~btn_step;
      run_cycles(2, en, first);
      check("bounce_en", 32'(en), 32'd0);
    end
    btn_step = 1'b0;
    run_cycles(10, en, first);
    check("bounce_cycle_cnt", cycle_cnt, 32'd1);
    check("bounce_state", 32'(state), 32'd0);

`ifdef STEP_CONTROLLER_BURST_EN
    // Burst of 5: remaining count 5,4,3,2,1 while enabled.
    do_reset();
    obs_q.delete();
    exp_q = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    burst_len = 8'd5;
    btn_burst = 1'b1;
    run_cycles(20, en, first);
    check("burst_en_cycles", 32'(en), 32'd5);
    check("burst_latency", 32'(first), 32'd6);
    check("burst_rem_len", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("burst_rem_seq", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    check("burst_rem_end", 32'(burst_rem), 32'd0);
    check("burst_cycle_cnt", cycle_cnt, 32'd5);
    check("burst_state_end", 32'(state), 32'd0);
    btn_burst = 1'b0;
    run_cycles(10, en, first);
`endif

    // Run, halt request after 10 enabled cycles.
    do_reset();
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    check("run_enter_state", 32'(state), 32'd1);
    btn_run = 1'b0;
    repeat (9) @(negedge clk);
    check("run_still_run", 32'(state), 32'd1);
    halt_req = 1'b1;
    @(negedge clk);
    check("halt_req_state", 32'(state), 32'd0);
    check("halt_req_clk_en", 32'(clk_en), 32'd0);
    check("halt_req_cycle_cnt", cycle_cnt, 32'd10);
    // Run press blocked by the pending halt request.
    btn_run = 1'b1;
    run_cycles(12, en, first);
    check("run_blocked_en", 32'(en), 32'd0);
    btn_run = 1'b0;
    run_cycles(10, en, first);
    // Step press still allowed under halt request.
    btn_step = 1'b1;
    run_cycles(12, en, first);
    check("step_under_halt_en", 32'(en), 32'd1);
    check("step_under_halt_cnt", cycle_cnt, 32'd11);
    check("step_under_halt_state", 32'(state), 32'd0);
    btn_step = 1'b0;
    halt_req = 1'b0;
    run_cycles(10, en, first);

    // Simultaneous run and step: run wins and stays running.
    do_reset();
    btn_run  = 1'b1;
    btn_step = 1'b1;
    repeat (6) @(negedge clk);
    check("run_step_prio", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    check("run_step_hold", 32'(state), 32'd1);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    halt_req = 1'b1;
    @(negedge clk);
    check("run_step_halted", 32'(state), 32'd0);
    halt_req = 1'b0;
    run_cycles(10, en, first);

    // Burst press that must not start a burst: zero length, or any length
    // when burst support is compiled out.
`ifdef STEP_CONTROLLER_BURST_EN
    burst_len = 8'd0;
`else
    burst_len = 8'd5;
`endif
    obs_q.delete();
    btn_burst = 1'b1;
    run_cycles(15, en, first);
    check("burst_noop_en", 32'(en), 32'd0);
    check("burst_noop_state", 32'(state), 32'd0);
    check("burst_noop_rem", 32'(burst_rem), 32'd0);
    btn_burst = 1'b0;
    run_cycles(10, en, first);

    // Reset mid-RUN drops the enable immediately.
    do_reset();
    btn_run = 1'b1;
    repeat (8) @(negedge clk);
    check("midrun_pre_en", 32'(clk_en), 32'd1);
    check("midrun_pre_cnt", cycle_cnt, 32'd2);
    btn_run = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_en", 32'(clk_en), 32'd0);
    check("midrun_rst_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(12, en, first);
    check("midrun_after_en", 32'(en), 32'd0);

`ifdef STEP_CONTROLLER_BURST_EN
    // Reset mid-burst at remaining count 3.
    do_reset();
    burst_len = 8'd5;
    btn_burst = 1'b1;
    repeat (8) @(negedge clk);
    check("midburst_pre_rem", 32'(burst_rem), 32'd3);
    check("midburst_pre_en", 32'(clk_en), 32'd1);
    #1 rst_n = 1'b0;
    btn_burst = 1'b0;
    #1;
    check("midburst_rst_en", 32'(clk_en), 32'd0);
    check("midburst_rst_rem", 32'(burst_rem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(12, en, first);
    check("midburst_after_en", 32'(en), 32'd0);
    check("midburst_after_state", 32'(state), 32'd0);
    check("midburst_after_rem", 32'(burst_rem), 32'd0);
    check("midburst_after_cnt", cycle_cnt, 32'd0);
`endif

    // Button held through reset yields exactly one press after release.
    @(negedge clk);
    btn_step = 1'b1;
    rst_n    = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    run_cycles(20, en, first);
    check("held_thru_rst_en", 32'(en), 32'd1);
    check("held_thru_rst_latency", 32'(first), 32'd6);
    check("held_thru_rst_cnt", cycle_cnt, 32'd1);
    btn_step = 1'b0;
    run_cycles(10, en, first);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
